// File: rtl/mini_alu_core.sv
// mini_alu_core: two-stage fetch/execute micro-sequencer with an internal
// dual-read register file, LED register, halt state and optional return stack.
// Optional feature macro: MINIALU_CALL_STACK_EN builds the CALL/RET return
// stack with overflow/underflow reporting; without it CALL/RET are NOPs and
// oStackError is tied low.
module mini_alu_core #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int IP_WIDTH    = 16,
    parameter int LED_WIDTH   = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                      Clock,
    input  logic                      Reset,
    output logic [IP_WIDTH-1:0]       oInstrAddr,
    input  logic [4+3*ADDR_WIDTH-1:0] iInstruction,
    output logic [LED_WIDTH-1:0]      oLed,
    output logic                      oHalted,
    output logic                      oStackError
);

    localparam int INSTR_W  = 4 + 3 * ADDR_WIDTH;
    localparam int RF_DEPTH = 1 << ADDR_WIDTH;
    localparam int SHAMT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [3:0] OP_LED  = 4'h1;
    localparam logic [3:0] OP_BLE  = 4'h2;
    localparam logic [3:0] OP_STO  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
`ifdef MINIALU_CALL_STACK_EN
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
`endif
    localparam logic [3:0] OP_HLT  = 4'hD;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Reject parameter sets the datapath cannot honour.
    if (LED_WIDTH > DATA_WIDTH || STACK_DEPTH < 1) begin : g_param_check
        $error("mini_alu_core: LED_WIDTH must be <= DATA_WIDTH and STACK_DEPTH >= 1");
    end

    logic [IP_WIDTH-1:0]   ip_q, ip_d;
    logic [INSTR_W-1:0]    ir_q, ir_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    state_e                state_q, state_d;

    logic [DATA_WIDTH-1:0] rf_q [RF_DEPTH];

    logic [3:0]            op;
    logic [ADDR_WIDTH-1:0] dest;
    logic [ADDR_WIDTH-1:0] src1;
    logic [ADDR_WIDTH-1:0] src0;
    logic [DATA_WIDTH-1:0] d1;
    logic [DATA_WIDTH-1:0] d0;

    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  take;
    logic [IP_WIDTH-1:0]   target;
    logic [IP_WIDTH-1:0]   fetch_addr;

`ifdef MINIALU_CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [SP_W-1:0]     sp_q, sp_d;
    logic                err_q, err_d;
    logic                push;
    logic [IDX_W-1:0]    push_idx;
    logic [IDX_W-1:0]    pop_idx;
    // Storage rounded up to a power of two so the index width is exact.
    logic [IP_WIDTH-1:0] stack_q [1 << IDX_W];
`endif

    assign {op, dest, src1, src0} = ir_q;
    assign d1 = rf_q[src1];
    assign d0 = rf_q[src0];

    // Execute stage: decode IR, form ALU result and branch decision, then
    // choose the next fetch address and what IR/IP capture at the edge.
    always_comb begin
        ip_d     = ip_q;
        ir_d     = ir_q;
        led_d    = led_q;
        state_d  = state_q;
        rf_we    = 1'b0;
        rf_wdata = '0;
        take     = 1'b0;
        target   = IP_WIDTH'(dest);
`ifdef MINIALU_CALL_STACK_EN
        sp_d     = sp_q;
        err_d    = err_q;
        push     = 1'b0;
        push_idx = IDX_W'(sp_q);
        pop_idx  = IDX_W'(sp_q - SP_W'(1));
`endif

        if (state_q == ST_RUN) begin
            case (op)
                OP_LED: led_d = d1[LED_WIDTH-1:0];
                OP_BLE: take = (d1 <= d0);
                OP_STO: begin
                    rf_we    = 1'b1;
                    rf_wdata = DATA_WIDTH'({src1, src0});
                end
                OP_ADD: begin
                    rf_we    = 1'b1;
                    rf_wdata = d1 + d0;
                end
                OP_JMP: take = 1'b1;
                OP_SUB: begin
                    rf_we    = 1'b1;
                    rf_wdata = d1 - d0;
                end
                OP_AND: begin
                    rf_we    = 1'b1;
                    rf_wdata = d1 & d0;
                end
                OP_OR: begin
                    rf_we    = 1'b1;
                    rf_wdata = d1 | d0;
                end
                OP_XOR: begin
                    rf_we    = 1'b1;
                    rf_wdata = d1 ^ d0;
                end
                OP_SHL: begin
                    rf_we    = 1'b1;
                    rf_wdata = d1 << d0[SHAMT_W-1:0];
                end
`ifdef MINIALU_CALL_STACK_EN
                OP_CALL: begin
                    if (sp_q == SP_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SP_W'(1);
                        take = 1'b1;
                    end
                end
                OP_RET: begin
                    if (sp_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        sp_d   = sp_q - SP_W'(1);
                        target = stack_q[pop_idx];
                        take   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end

        // A taken branch redirects this cycle's fetch so no bubble is needed.
        fetch_addr = take ? target : ip_q;

        if (state_q == ST_RUN) begin
            if (op == OP_HLT) begin
                ir_d    = '0;
                state_d = ST_HALT;
            end else begin
                ir_d = iInstruction;
                ip_d = fetch_addr + IP_WIDTH'(1);
            end
        end
    end

    // Control state: instruction pointer, instruction register, LED, run/halt.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ip_q    <= '0;
            ir_q    <= '0;
            led_q   <= '0;
            state_q <= ST_RUN;
        end else begin
            ip_q    <= ip_d;
            ir_q    <= ir_d;
            led_q   <= led_d;
            state_q <= state_d;
        end
    end

    // Register file write port; contents are deliberately not reset.
    always_ff @(posedge Clock) begin
        if (rf_we) begin
            rf_q[dest] <= rf_wdata;
        end
    end

`ifdef MINIALU_CALL_STACK_EN
    // Return-stack pointer and sticky overflow/underflow flag.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-stack storage: a successful CALL saves the address after it.
    always_ff @(posedge Clock) begin
        if (push) begin
            stack_q[push_idx] <= ip_q;
        end
    end

    assign oStackError = err_q;
`else
    assign oStackError = 1'b0;
`endif

    assign oInstrAddr = fetch_addr;
    assign oLed       = led_q;
    assign oHalted    = (state_q == ST_HALT);

endmodule
